csr_counter_unit: RTL and testbench

- Consumes the execute-stage CSR controls (CSREn, CSRSel) and the memory-stage MMIO load/store requests of the 3-stage RISC-V core.
- Holds the tohost CSR (0x51E), a free-running cycle counter and a retired-instruction counter.
- Counters are read through memory-mapped addresses and cleared through a memory-mapped write.
- Read data returns with 1-cycle registered latency, matching the DMEM/BIOS read timing the writeback mux expects.

---
 rtl/csr_counter_unit.sv | 74 +++++++
 tb/tb_csr_counter_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_unit.sv
// CSR/MMIO side block of the 3-stage core: tohost CSR plus cycle and retired-instruction
// counters readable over MMIO with one cycle of registered read latency.
module csr_counter_unit #(
    parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
    parameter logic [31:0] CYCLE_ADDR   = 32'h8000_0010,
    parameter logic [31:0] INSTRET_ADDR = 32'h8000_0014,
    parameter logic [31:0] CNT_RST_ADDR = 32'h8000_0018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic        csr_sel,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        retire,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic        mmio_we,
    output logic [31:0] mmio_rdata,
    output logic        mmio_rvalid,
    output logic [31:0] tohost,
    output logic        tohost_wr,
    output logic        test_done
);

    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    logic [31:0] tohost_wdata;
    logic        tohost_hit;
    logic        cnt_clr;
    logic        rd_cycle;
    logic        rd_instret;

    assign tohost_hit   = csr_en && (csr_addr == TOHOST_ADDR);
    assign tohost_wdata = csr_sel ? {27'b0, zimm} : rs1_data;
    assign cnt_clr      = mmio_we && (mmio_addr == CNT_RST_ADDR);
    assign rd_cycle     = mmio_re && (mmio_addr == CYCLE_ADDR);
    assign rd_instret   = mmio_re && (mmio_addr == INSTRET_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost      <= '0;
            tohost_wr   <= 1'b0;
            test_done   <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            mmio_rdata  <= '0;
            mmio_rvalid <= 1'b0;
        end else begin
            tohost_wr <= tohost_hit;
            if (tohost_hit)
                tohost <= tohost_wdata;
            // Sticky: only reset clears it, later writes with bit0=0 do not.
            if (tohost_hit && tohost_wdata[0])
                test_done <= 1'b1;

            // Clear beats the same-cycle increment.
            cycle_cnt <= cnt_clr ? '0 : cycle_cnt + 32'd1;
            if (cnt_clr)
                instret_cnt <= '0;
            else if (retire)
                instret_cnt <= instret_cnt + 32'd1;

            // Reads return the pre-update (and pre-clear) counter value.
            mmio_rvalid <= rd_cycle || rd_instret;
            if (rd_cycle)
                mmio_rdata <= cycle_cnt;
            else if (rd_instret)
                mmio_rdata <= instret_cnt;
        end
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Self-checking bench for csr_counter_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the CSR/counter rules.
module tb_csr_counter_unit;

    localparam logic [11:0] TOHOST  = 12'h51E;
    localparam logic [31:0] CYC     = 32'h8000_0010;
    localparam logic [31:0] INS     = 32'h8000_0014;
    localparam logic [31:0] CNT_RST = 32'h8000_0018;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic        csr_sel;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        retire;
    logic [31:0] mmio_addr;
    logic        mmio_re;
    logic        mmio_we;
    logic [31:0] mmio_rdata;
    logic        mmio_rvalid;
    logic [31:0] tohost;
    logic        tohost_wr;
    logic        test_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_cycle, m_instret, m_tohost, m_rdata;
    logic        m_tohost_wr, m_test_done, m_rvalid;

    csr_counter_unit dut (
        .clk(clk), .rst(rst), .csr_en(csr_en), .csr_sel(csr_sel), .csr_addr(csr_addr),
        .rs1_data(rs1_data), .zimm(zimm), .retire(retire), .mmio_addr(mmio_addr),
        .mmio_re(mmio_re), .mmio_we(mmio_we), .mmio_rdata(mmio_rdata),
        .mmio_rvalid(mmio_rvalid), .tohost(tohost), .tohost_wr(tohost_wr),
        .test_done(test_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        csr_en = 0; csr_sel = 0; csr_addr = '0; rs1_data = '0; zimm = '0;
        retire = 0; mmio_addr = '0; mmio_re = 0; mmio_we = 0;
    endtask

    // Advance one clock; the model applies the rules to the inputs present at the edge.
    task automatic tick();
        logic [31:0] wdata;
        @(posedge clk);
        if (rst) begin
            m_cycle = 0; m_instret = 0; m_tohost = 0; m_rdata = 0;
            m_tohost_wr = 0; m_test_done = 0; m_rvalid = 0;
        end else begin
            if (mmio_re && (mmio_addr == CYC || mmio_addr == INS)) begin
                m_rvalid = 1;
                m_rdata  = (mmio_addr == CYC) ? m_cycle : m_instret;
            end else begin
                m_rvalid = 0;
            end
            wdata = csr_sel ? 32'(zimm) : rs1_data;
            m_tohost_wr = csr_en && csr_addr == TOHOST;
            if (m_tohost_wr) begin
                m_tohost = wdata;
                if (wdata % 2 == 1) m_test_done = 1;
            end
            if (mmio_we && mmio_addr == CNT_RST) begin
                m_cycle = 0; m_instret = 0;
            end else begin
                m_cycle   = m_cycle + 1;
                m_instret = m_instret + (retire ? 1 : 0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({mmio_rdata, mmio_rvalid, tohost, tohost_wr, test_done} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: got rdata=%h rvalid=%b tohost=%h wr=%b done=%b, want all 0",
                         i, mmio_rdata, mmio_rvalid, tohost, tohost_wr, test_done);
            end
        end
        rst = 0;
        repeat (10) tick();
        mmio_re = 1; mmio_addr = CYC;
        tick();
        mmio_re = 0;
        n_tests++;
        if (mmio_rdata !== 32'd10 || mmio_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cycle_read: got rdata=%0d rvalid=%b, want 10/1", mmio_rdata, mmio_rvalid);
        end
        tick();
        n_tests++;
        if (mmio_rvalid !== 1'b0 || mmio_rdata !== 32'd10) begin
            n_fail++;
            $display("FAIL rvalid_single_cycle: got rvalid=%b rdata=%0d, want 0 and held 10", mmio_rvalid, mmio_rdata);
        end
    endtask

    task automatic test_tohost();
        csr_en = 1; csr_sel = 0; csr_addr = TOHOST; rs1_data = 32'hDEADBEEF;
        tick();
        csr_en = 0;
        n_tests++;
        if (tohost !== 32'hDEADBEEF || tohost_wr !== 1'b1 || test_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tohost_rs1: got tohost=%h wr=%b done=%b, want deadbeef/1/1", tohost, tohost_wr, test_done);
        end
        tick();
        n_tests++;
        if (tohost_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL tohost_wr_pulse: got wr=%b, want 0", tohost_wr);
        end
        csr_en = 1; csr_sel = 1; zimm = 5'h1E; rs1_data = $urandom;
        tick();
        csr_en = 0;
        n_tests++;
        if (tohost !== 32'h0000001E || test_done !== 1'b1 || tohost_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL tohost_zimm: got tohost=%h done=%b wr=%b, want 0000001e/1/1", tohost, test_done, tohost_wr);
        end
        tick();
    endtask

    task automatic test_wrong_csr();
        csr_en = 1; csr_sel = 0; csr_addr = 12'h51F; rs1_data = 32'h1;
        tick();
        csr_en = 0;
        n_tests++;
        if (tohost !== 32'h0000001E || tohost_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_csr_addr: got tohost=%h wr=%b, want 0000001e/0", tohost, tohost_wr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            csr_en = 1; csr_addr = TOHOST; csr_sel = 1'($urandom);
            rs1_data = $urandom; zimm = 5'($urandom);
            tick();
            n_tests++;
            if (tohost !== m_tohost || tohost_wr !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got tohost=%h wr=%b, want %h/1", i, tohost, tohost_wr, m_tohost);
            end
        end
        csr_en = 0;
        tick();
        n_tests++;
        if (tohost_wr !== 1'b0 || tohost !== m_tohost) begin
            n_fail++;
            $display("FAIL back_to_back_end: got wr=%b tohost=%h, want 0/%h", tohost_wr, tohost, m_tohost);
        end
    endtask

    task automatic test_instret();
        logic pat [12];
        for (int i = 0; i < 12; i++) pat[i] = (i < 7);
        for (int i = 11; i > 0; i--) begin
            int j;
            logic t;
            j = $urandom_range(i, 0);
            t = pat[i]; pat[i] = pat[j]; pat[j] = t;
        end
        for (int i = 0; i < 12; i++) begin
            retire = pat[i];
            tick();
        end
        retire = 0;
        mmio_re = 1; mmio_addr = INS;
        tick();
        mmio_re = 0;
        n_tests++;
        if (mmio_rdata !== 32'd7 || mmio_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL instret_read: got rdata=%0d rvalid=%b, want 7/1", mmio_rdata, mmio_rvalid);
        end
    endtask

    task automatic test_clear();
        mmio_we = 1; mmio_addr = CNT_RST; retire = 1;
        tick();
        mmio_we = 0; retire = 0;
        mmio_re = 1; mmio_addr = INS;
        tick();
        n_tests++;
        if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_instret: got rdata=%0d rvalid=%b, want 0/1", mmio_rdata, mmio_rvalid);
        end
        mmio_addr = CYC;
        tick();
        mmio_re = 0;
        n_tests++;
        if (mmio_rdata !== 32'd1 || mmio_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_cycle: got rdata=%0d rvalid=%b, want 1/1", mmio_rdata, mmio_rvalid);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(49, 0) == 0);
            csr_en   = 1'($urandom);
            csr_sel  = 1'($urandom);
            case ($urandom_range(2, 0))
                0: csr_addr = TOHOST;
                1: csr_addr = 12'h51F;
                default: csr_addr = 12'($urandom);
            endcase
            rs1_data = $urandom;
            zimm     = 5'($urandom);
            retire   = 1'($urandom);
            case ($urandom_range(4, 0))
                0: mmio_addr = CYC;
                1: mmio_addr = INS;
                2: mmio_addr = CNT_RST;
                3: mmio_addr = CYC ^ 32'h0001_0000;
                default: mmio_addr = $urandom;
            endcase
            mmio_re  = ($urandom_range(2, 0) != 0);
            mmio_we  = ($urandom_range(5, 0) == 0);
            tick();
            n_tests++;
            if ({mmio_rdata, mmio_rvalid, tohost, tohost_wr, test_done} !==
                {m_rdata, m_rvalid, m_tohost, m_tohost_wr, m_test_done}) begin
                n_fail++;
                $display("FAIL random_%0d: got rdata=%h rv=%b th=%h wr=%b done=%b, want %h %b %h %b %b",
                         i, mmio_rdata, mmio_rvalid, tohost, tohost_wr, test_done,
                         m_rdata, m_rvalid, m_tohost, m_tohost_wr, m_test_done);
            end
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_wrap();
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        m_cycle = 32'hFFFF_FFFE;
        repeat (3) tick();
        mmio_re = 1; mmio_addr = CYC;
        tick();
        mmio_re = 0;
        n_tests++;
        if (mmio_rdata !== 32'h0000_0001 || m_rdata !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL cycle_wrap: got rdata=%h (model %h), want 00000001", mmio_rdata, m_rdata);
        end
    endtask

    task automatic test_mid_reset();
        csr_en = 1; csr_addr = TOHOST; csr_sel = 0; rs1_data = 32'h0000_0003; retire = 1;
        tick();
        mmio_re = 1; mmio_addr = INS; rst = 1;
        tick();
        idle_inputs();
        rst = 0;
        n_tests++;
        if ({mmio_rdata, mmio_rvalid, tohost, tohost_wr, test_done} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdata=%h rvalid=%b tohost=%h wr=%b done=%b, want all 0",
                     mmio_rdata, mmio_rvalid, tohost, tohost_wr, test_done);
        end
        mmio_re = 1; mmio_addr = CYC;
        tick();
        n_tests++;
        if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_cycle: got rdata=%0d rvalid=%b, want 0/1", mmio_rdata, mmio_rvalid);
        end
        mmio_addr = INS;
        tick();
        mmio_re = 0;
        n_tests++;
        if (mmio_rdata !== 32'd0 || mmio_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_instret: got rdata=%0d rvalid=%b, want 0/1", mmio_rdata, mmio_rvalid);
        end
    endtask

    initial begin
        clk = 0;
        rst = 1;
        idle_inputs();
        m_cycle = 0; m_instret = 0; m_tohost = 0; m_rdata = 0;
        m_tohost_wr = 0; m_test_done = 0; m_rvalid = 0;
        test_reset();
        test_tohost();
        test_wrong_csr();
        test_back_to_back();
        test_instret();
        test_clear();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
